// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared maze dimensions and loader state encoding
package maze_pkg;

   // Default maze geometry shared with memory_block and the maze controller
   localparam int MAZE_WIDTH  = 16;
   localparam int MAZE_HEIGHT = 16;
   localparam int MAZE_ADDR_W = 4;
   localparam int MAZE_ADDR_H = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_DONE = 2'd2
   } load_state_t;

endpackage

// File: rtl/maze_loader_cell_address_gen.sv
// rtl/maze_loader_cell_address_gen.sv - raster x/y cell counter, x fastest
module cell_address_gen
   import maze_pkg::*;
#(
   parameter int WIDTH  = MAZE_WIDTH,
   parameter int HEIGHT = MAZE_HEIGHT,
   parameter int ADDR_W = MAZE_ADDR_W,
   parameter int ADDR_H = MAZE_ADDR_H
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   output logic [ADDR_W-1:0] x,
   output logic [ADDR_H-1:0] y,
   output logic              last_cell
);

   // Wrap on the real maze size, which need not be a power of two
   localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(WIDTH - 1);
   localparam logic [ADDR_H-1:0] Y_LAST = ADDR_H'(HEIGHT - 1);

   logic end_of_row;

   assign end_of_row = (x == X_LAST);
   assign last_cell  = end_of_row && (y == Y_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x <= '0;
         y <= '0;
      end else if (clr) begin
         x <= '0;
         y <= '0;
      end else if (en) begin
         if (last_cell) begin
            x <= '0;
            y <= '0;
         end else if (end_of_row) begin
            x <= '0;
            y <= y + ADDR_H'(1);
         end else begin
            x <= x + ADDR_W'(1);
         end
      end
   end

endmodule

// File: rtl/maze_loader.sv
// rtl/maze_loader.sv - streams a serial map bitstream into the maze memory in raster order
module maze_loader
   import maze_pkg::*;
#(
   parameter int WIDTH  = MAZE_WIDTH,
   parameter int HEIGHT = MAZE_HEIGHT,
   parameter int ADDR_W = MAZE_ADDR_W,
   parameter int ADDR_H = MAZE_ADDR_H
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     abort,
   input  logic                     in_valid,
   input  logic                     in_data,
   output logic                     in_ready,
   output logic                     mem_wr,
   output logic [ADDR_W-1:0]        mem_addr_x,
   output logic [ADDR_H-1:0]        mem_addr_y,
   output logic                     mem_data,
   output logic                     busy,
   output logic                     done,
   output logic                     loaded,
   output logic [ADDR_W+ADDR_H:0]   wall_count
);

   localparam int CNT_W = ADDR_W + ADDR_H + 1;

   load_state_t state;
   logic        transfer;
   logic        addr_clr;
   logic        last_cell;

   // Abort outranks a same-cycle handshake so a cancelled load never writes
   assign in_ready = busy;
   assign transfer = in_valid & busy & ~abort;
   assign mem_wr   = transfer;
   assign mem_data = in_data;
   assign addr_clr = (state == S_IDLE) && start;

   cell_address_gen #(
      .WIDTH  (WIDTH),
      .HEIGHT (HEIGHT),
      .ADDR_W (ADDR_W),
      .ADDR_H (ADDR_H)
   ) u_addr (
      .clk       (clk),
      .rst       (rst),
      .clr       (addr_clr),
      .en        (transfer),
      .x         (mem_addr_x),
      .y         (mem_addr_y),
      .last_cell (last_cell)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         loaded     <= 1'b0;
         wall_count <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state      <= S_LOAD;
                  busy       <= 1'b1;
                  loaded     <= 1'b0;
                  wall_count <= '0;
               end
            end
            S_LOAD: begin
               if (abort) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else if (transfer) begin
                  if (in_data)
                     wall_count <= wall_count + CNT_W'(1);
                  if (last_cell) begin
                     state <= S_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               state  <= S_IDLE;
               loaded <= 1'b1;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_maze_loader.sv
// tb/tb_maze_loader.sv - randomized self-checking bench for maze_loader
module tb_maze_loader;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0, abort = 1'b0, in_valid = 1'b0, in_data = 1'b0;
   logic       in_ready, mem_wr, mem_data, busy, done, loaded;
   logic [3:0] mem_addr_x, mem_addr_y;
   logic [8:0] wall_count;

   logic       b_start = 1'b0, b_abort = 1'b0, b_in_valid = 1'b0, b_in_data = 1'b0;
   logic       b_in_ready, b_mem_wr, b_mem_data, b_busy, b_done, b_loaded;
   logic [2:0] b_x;
   logic [1:0] b_y;
   logic [5:0] b_wall_count;

   int         n_vec = 0;
   int         n_err = 0;
   logic       mem_model [256];

   always #5 clk = ~clk;

   maze_loader dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .mem_wr(mem_wr), .mem_addr_x(mem_addr_x), .mem_addr_y(mem_addr_y),
      .mem_data(mem_data), .busy(busy), .done(done), .loaded(loaded),
      .wall_count(wall_count)
   );

   maze_loader #(.WIDTH(5), .HEIGHT(3), .ADDR_W(3), .ADDR_H(2)) dut_small (
      .clk(clk), .rst(rst), .start(b_start), .abort(b_abort),
      .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
      .mem_wr(b_mem_wr), .mem_addr_x(b_x), .mem_addr_y(b_y),
      .mem_data(b_mem_data), .busy(b_busy), .done(b_done), .loaded(b_loaded),
      .wall_count(b_wall_count)
   );

   // Behavioural memory_block: captures on the edge the handshake completes
   always @(posedge clk)
      if (mem_wr) mem_model[{mem_addr_y, mem_addr_x}] <= mem_data;

   function automatic int count_walls(input logic [255:0] map, input int k);
      int c = 0;
      for (int i = 0; i < k; i++) c += int'(map[i]);
      return c;
   endfunction

   function automatic logic [255:0] random_map();
      logic [255:0] m;
      for (int i = 0; i < 8; i++) m[i*32 +: 32] = $urandom;
      return m;
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 256; i++) mem_model[i] = 1'b0;
   endtask

   task automatic do_start(input logic with_abort);
      start = 1'b1;
      abort = with_abort;
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      n_vec++;
      if (busy !== 1'b1 || in_ready !== 1'b1 || loaded !== 1'b0 || wall_count !== 9'd0 ||
          mem_addr_x !== 4'd0 || mem_addr_y !== 4'd0) begin
         n_err++;
         $display("FAIL start_state busy=%b rdy=%b loaded=%b walls=%0d x=%0d y=%0d want 1 1 0 0 0 0",
                  busy, in_ready, loaded, wall_count, mem_addr_x, mem_addr_y);
      end
   endtask

   // Streams bits first..first+n-1 of map; every cycle checks the write strobe and target cell
   task automatic stream_bits(input logic [255:0] map, input int valid_pct, input int first,
                              input int n, output int cycles);
      int idx = first;
      cycles = 0;
      while (idx < first + n && cycles < 4000) begin
         in_valid = ($urandom_range(0, 99) < valid_pct);
         in_data  = map[idx];
         #1;
         n_vec++;
         if (mem_wr !== in_valid || in_ready !== 1'b1 || done !== 1'b0) begin
            n_err++;
            $display("FAIL write_strobe idx=%0d wr=%b rdy=%b done=%b want wr=%b rdy=1 done=0",
                     idx, mem_wr, in_ready, done, in_valid);
         end else if (in_valid && (mem_addr_x !== 4'(idx % 16) || mem_addr_y !== 4'(idx / 16) ||
                                   mem_data !== map[idx])) begin
            n_err++;
            $display("FAIL write_cell idx=%0d got (%0d,%0d)=%b want (%0d,%0d)=%b",
                     idx, mem_addr_x, mem_addr_y, mem_data, idx % 16, idx / 16, map[idx]);
         end
         @(negedge clk);
         cycles++;
         if (in_valid) idx++;
      end
      in_valid = 1'b0;
      n_vec++;
      if (idx != first + n) begin
         n_err++;
         $display("FAIL stream_timeout accepted=%0d want %0d", idx - first, n);
      end
   endtask

   task automatic check_completion(input logic [255:0] map, input int exp_walls);
      int bad = 0;
      n_vec++;
      if (done !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 || loaded !== 1'b0 ||
          wall_count !== 9'(exp_walls)) begin
         n_err++;
         $display("FAIL done_pulse done=%b busy=%b rdy=%b loaded=%b walls=%0d want 1 0 0 0 %0d",
                  done, busy, in_ready, loaded, wall_count, exp_walls);
      end
      @(negedge clk);
      n_vec++;
      if (done !== 1'b0 || loaded !== 1'b1 || wall_count !== 9'(exp_walls)) begin
         n_err++;
         $display("FAIL loaded_level done=%b loaded=%b walls=%0d want 0 1 %0d",
                  done, loaded, wall_count, exp_walls);
      end
      for (int i = 0; i < 256; i++) if (mem_model[i] !== map[i]) bad++;
      n_vec++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL mem_readback bad_cells=%0d want 0", bad);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_vec++;
      if ({busy, in_ready, mem_wr, done, loaded} !== 5'b0 || wall_count !== 9'd0 ||
          mem_addr_x !== 4'd0 || mem_addr_y !== 4'd0) begin
         n_err++;
         $display("FAIL reset_state flags=%b walls=%0d x=%0d y=%0d want 00000 0 0 0",
                  {busy, in_ready, mem_wr, done, loaded}, wall_count, mem_addr_x, mem_addr_y);
      end
      n_vec++;
      if ({b_busy, b_in_ready, b_mem_wr, b_done, b_loaded} !== 5'b0 || b_wall_count !== 6'd0) begin
         n_err++;
         $display("FAIL reset_small flags=%b walls=%0d want 00000 0",
                  {b_busy, b_in_ready, b_mem_wr, b_done, b_loaded}, b_wall_count);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_full_stream();
      logic [255:0] map = random_map();
      int cycles;
      clear_model();
      do_start(1'b0);
      stream_bits(map, 100, 0, 256, cycles);
      n_vec++;
      if (cycles != 256) begin
         n_err++;
         $display("FAIL back_to_back_cycles got %0d want 256", cycles);
      end
      check_completion(map, count_walls(map, 256));
   endtask

   task automatic test_valid_gaps();
      logic [255:0] map;
      logic [15:0]  pat = 16'hAAAA;
      int cycles;
      for (int i = 0; i < 256; i++) map[i] = pat[i % 16];
      clear_model();
      do_start(1'b0);
      stream_bits(map, 45, 0, 256, cycles);
      check_completion(map, 128);
   endtask

   task automatic test_small_maze();
      int idx = 0, walls = 0, budget = 0;
      b_start = 1'b1;
      @(negedge clk);
      b_start = 1'b0;
      while (idx < 15 && budget < 500) begin
         b_in_valid = ($urandom_range(0, 99) < 60);
         b_in_data  = 1'($urandom_range(0, 1));
         #1;
         n_vec++;
         if (b_mem_wr !== b_in_valid || b_in_ready !== 1'b1 || b_done !== 1'b0) begin
            n_err++;
            $display("FAIL small_strobe idx=%0d wr=%b rdy=%b done=%b want wr=%b rdy=1 done=0",
                     idx, b_mem_wr, b_in_ready, b_done, b_in_valid);
         end else if (b_in_valid && (b_x !== 3'(idx % 5) || b_y !== 2'(idx / 5) ||
                                     b_mem_data !== b_in_data)) begin
            n_err++;
            $display("FAIL small_cell idx=%0d got (%0d,%0d) want (%0d,%0d)",
                     idx, b_x, b_y, idx % 5, idx / 5);
         end
         @(negedge clk);
         budget++;
         if (b_in_valid) begin
            walls += int'(b_in_data);
            idx++;
         end
      end
      b_in_valid = 1'b0;
      n_vec++;
      if (idx != 15 || b_done !== 1'b1 || b_busy !== 1'b0 || b_wall_count !== 6'(walls) ||
          b_x !== 3'd0 || b_y !== 2'd0) begin
         n_err++;
         $display("FAIL small_done n=%0d done=%b busy=%b walls=%0d x=%0d y=%0d want 15 1 0 %0d 0 0",
                  idx, b_done, b_busy, b_wall_count, b_x, b_y, walls);
      end
      @(negedge clk);
      n_vec++;
      if (b_loaded !== 1'b1 || b_done !== 1'b0) begin
         n_err++;
         $display("FAIL small_loaded loaded=%b done=%b want 1 0", b_loaded, b_done);
      end
   endtask

   task automatic test_abort();
      logic [255:0] map = random_map();
      int cycles, stray = 0;
      do_start(1'b0);
      stream_bits(map, 100, 0, 40, cycles);
      abort    = 1'b1;
      in_valid = 1'b1;
      in_data  = map[40];
      #1;
      n_vec++;
      if (mem_wr !== 1'b0) begin
         n_err++;
         $display("FAIL abort_write wr=%b want 0", mem_wr);
      end
      @(negedge clk);
      abort    = 1'b0;
      in_valid = 1'b0;
      n_vec++;
      if (busy !== 1'b0 || in_ready !== 1'b0 || wall_count !== 9'(count_walls(map, 40))) begin
         n_err++;
         $display("FAIL abort_state busy=%b rdy=%b walls=%0d want 0 0 %0d",
                  busy, in_ready, wall_count, count_walls(map, 40));
      end
      repeat (3) begin
         if (done !== 1'b0 || loaded !== 1'b0) stray++;
         @(negedge clk);
      end
      n_vec++;
      if (stray != 0) begin
         n_err++;
         $display("FAIL abort_no_done stray_cycles=%0d want 0", stray);
      end
      do_start(1'b0);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
   endtask

   task automatic test_start_then_rst();
      logic [255:0] map = '1;
      int cycles;
      do_start(1'b0);
      stream_bits(map, 100, 0, 20, cycles);
      start    = 1'b1;
      in_valid = 1'b1;
      in_data  = 1'b1;
      #1;
      n_vec++;
      if (mem_wr !== 1'b1 || mem_addr_x !== 4'd4 || mem_addr_y !== 4'd1) begin
         n_err++;
         $display("FAIL start_in_load wr=%b x=%0d y=%0d want 1 4 1", mem_wr, mem_addr_x, mem_addr_y);
      end
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b0;
      #1;
      n_vec++;
      if (busy !== 1'b1 || mem_addr_x !== 4'd5 || mem_addr_y !== 4'd1 || wall_count !== 9'd21) begin
         n_err++;
         $display("FAIL start_ignored busy=%b x=%0d y=%0d walls=%0d want 1 5 1 21",
                  busy, mem_addr_x, mem_addr_y, wall_count);
      end
      in_valid = 1'b1;
      rst      = 1'b1;
      #1;
      n_vec++;
      if ({busy, in_ready, mem_wr, done, loaded} !== 5'b0 || wall_count !== 9'd0 ||
          mem_addr_x !== 4'd0 || mem_addr_y !== 4'd0) begin
         n_err++;
         $display("FAIL async_reset flags=%b walls=%0d x=%0d y=%0d want 00000 0 0 0",
                  {busy, in_ready, mem_wr, done, loaded}, wall_count, mem_addr_x, mem_addr_y);
      end
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_all_walls();
      logic [255:0] map = '1;
      int cycles;
      clear_model();
      do_start(1'b0);
      stream_bits(map, 70, 0, 256, cycles);
      check_completion(map, 256);
      do_start(1'b1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
   endtask

   initial begin
      test_reset();
      test_full_stream();
      test_valid_gaps();
      test_small_maze();
      test_abort();
      test_start_then_rst();
      test_all_walls();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end

endmodule
